// File: rtl/rom_stream_ctrl.sv
// ---------------------------------------------------------------------------
// rom_stream_ctrl
//   Reads a contiguous window of a combinational-read ROM and streams it out
//   one word per cycle over a valid/ready interface. Owns the ROM address,
//   registers the ROM word into a one-deep output stage, absorbs consumer
//   backpressure, and reports busy/done to the layer controller.
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   i_start      begin a burst (sampled only in IDLE)
//   i_abort      cancel any burst on the next edge; wins over i_start
//   i_base_addr  first ROM address of the burst (out-of-range loads as 0)
//   i_length     number of words in the burst (0 = no words, just done)
//   o_busy       high while not IDLE
//   o_done       one-cycle pulse after the last word is accepted
//   o_rom_addr   ROM address bus
//   i_rom_data   ROM read data, combinational from o_rom_addr
//   o_m_valid    output word valid
//   i_m_ready    consumer ready
//   o_m_data     streamed ROM word
//   o_m_last     marks the final word of the burst
// ---------------------------------------------------------------------------
module rom_stream_ctrl #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DATA_DEPTH = 16,
  localparam int ADDR_WIDTH = $clog2(DATA_DEPTH),
  localparam int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [LEN_WIDTH-1:0]  i_length,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  input  logic [DATA_WIDTH-1:0] i_rom_data,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic                  o_m_last
);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(DATA_DEPTH - 1);
  // Depth compared in the wider length domain so non-power-of-two depths
  // can detect out-of-range base addresses.
  localparam logic [LEN_WIDTH-1:0]  DEPTH_CMP  = LEN_WIDTH'(DATA_DEPTH);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [LEN_WIDTH-1:0]  r_rem;
  logic                  r_m_valid;
  logic                  r_m_last;
  logic [DATA_WIDTH-1:0] r_m_data;

  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] w_rd_addr_next;
  logic [LEN_WIDTH-1:0]  w_rem_next;
  logic                  w_m_valid_next;
  logic                  w_m_last_next;
  logic [DATA_WIDTH-1:0] w_m_data_next;

  logic                  w_load;
  logic                  w_hs;
  logic [ADDR_WIDTH-1:0] w_addr_inc;
  logic [ADDR_WIDTH-1:0] w_base_clamped;

  // The output stage refills whenever words remain and the stage is empty
  // or being drained this cycle, giving one word per cycle with no bubbles.
  assign w_load         = (r_rem != '0) && (!r_m_valid || i_m_ready);
  assign w_hs           = r_m_valid && i_m_ready;
  assign w_addr_inc     = (r_rd_addr == ADDR_LAST) ? '0 : r_rd_addr + 1'b1;
  assign w_base_clamped = ({1'b0, i_base_addr} < DEPTH_CMP) ? i_base_addr : '0;

  always_comb begin
    w_state_next   = r_state;
    w_rd_addr_next = r_rd_addr;
    w_rem_next     = r_rem;
    w_m_valid_next = r_m_valid;
    w_m_last_next  = r_m_last;
    w_m_data_next  = r_m_data;

    if (i_abort) begin
      w_state_next   = S_IDLE;
      w_m_valid_next = 1'b0;
      w_m_last_next  = 1'b0;
      w_rem_next     = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (i_length != '0) begin
              w_rd_addr_next = w_base_clamped;
              w_rem_next     = i_length;
              w_state_next   = S_STREAM;
            end else begin
              w_state_next   = S_DONE;
            end
          end
        end
        S_STREAM: begin
          if (w_load) begin
            w_m_data_next  = i_rom_data;
            w_m_valid_next = 1'b1;
            w_m_last_next  = (r_rem == LEN_WIDTH'(1));
            w_rd_addr_next = w_addr_inc;
            w_rem_next     = r_rem - 1'b1;
          end else if (w_hs) begin
            w_m_valid_next = 1'b0;
            w_m_last_next  = 1'b0;
          end
          // The last word can never coincide with a load (rem is 0 by then).
          if (w_hs && r_m_last) begin
            w_state_next = S_DONE;
          end
        end
        S_DONE: begin
          w_state_next = S_IDLE;
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_rd_addr <= '0;
      r_rem     <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_data  <= '0;
    end else begin
      r_state   <= w_state_next;
      r_rd_addr <= w_rd_addr_next;
      r_rem     <= w_rem_next;
      r_m_valid <= w_m_valid_next;
      r_m_last  <= w_m_last_next;
      r_m_data  <= w_m_data_next;
    end
  end

  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = (r_state == S_DONE);
  assign o_rom_addr = r_rd_addr;
  assign o_m_valid  = r_m_valid;
  assign o_m_last   = r_m_last;
  assign o_m_data   = r_m_data;

endmodule

// File: tb/tb_rom_stream_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rom_stream_ctrl
//   Directed bench for rom_stream_ctrl. Two instances: DEPTH=16 (main) and
//   DEPTH=10 (non-power-of-two wrap). Both ROMs hold mem[i] = i+1.
// ---------------------------------------------------------------------------
module tb_rom_stream_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  always #5 clk = ~clk;

  // DEPTH=16 instance
  logic       start, abort, ready;
  logic [3:0] base;
  logic [4:0] len;
  logic       busy, done, m_valid, m_last;
  logic [3:0] rom_addr;
  logic [7:0] rom_data, m_data;
  assign rom_data = 8'(rom_addr) + 8'd1;

  rom_stream_ctrl #(.DATA_WIDTH(8), .DATA_DEPTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_base_addr(base), .i_length(len), .o_busy(busy), .o_done(done),
    .o_rom_addr(rom_addr), .i_rom_data(rom_data), .o_m_valid(m_valid),
    .i_m_ready(ready), .o_m_data(m_data), .o_m_last(m_last)
  );

  // DEPTH=10 instance
  logic       start10, abort10, ready10;
  logic [3:0] base10;
  logic [4:0] len10;
  logic       busy10, done10, m_valid10, m_last10;
  logic [3:0] rom_addr10;
  logic [7:0] rom_data10, m_data10;
  assign rom_data10 = 8'(rom_addr10) + 8'd1;

  rom_stream_ctrl #(.DATA_WIDTH(8), .DATA_DEPTH(10)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .i_start(start10), .i_abort(abort10),
    .i_base_addr(base10), .i_length(len10), .o_busy(busy10), .o_done(done10),
    .o_rom_addr(rom_addr10), .i_rom_data(rom_data10), .o_m_valid(m_valid10),
    .i_m_ready(ready10), .o_m_data(m_data10), .o_m_last(m_last10)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int         acc;
  bit         have_prev;
  bit         got_done;
  logic [7:0] prev_data;

  initial begin
    rst_n = 1'b0; start = 0; abort = 0; ready = 0; base = 0; len = 0;
    start10 = 0; abort10 = 0; ready10 = 0; base10 = 0; len10 = 0;
    repeat (2) tick();
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_last",  32'(m_last),  32'd0);
    chk("rst_done",  32'(done),    32'd0);
    chk("rst_busy",  32'(busy),    32'd0);
    chk("rst_addr",  32'(rom_addr), 32'd0);
    chk("rst_data",  32'(m_data),  32'd0);
    rst_n = 1'b1;
    tick();

    // 1: base=3 len=4, ready held high
    base = 4'd3; len = 5'd4; ready = 1; start = 1;
    chk("t1_busy_c0", 32'(busy), 32'd0);
    tick(); start = 0;
    chk("t1_busy_c1",  32'(busy),    32'd1);
    chk("t1_valid_c1", 32'(m_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_valid", 32'(m_valid), 32'd1);
      chk("t1_data",  32'(m_data),  32'(4 + i));
      chk("t1_last",  32'(m_last),  32'(i == 3));
      chk("t1_busy",  32'(busy),    32'd1);
      $display("t1 word %0d data=%0d last=%0d", i, m_data, m_last);
    end
    tick();
    chk("t1_done_c6",  32'(done),    32'd1);
    chk("t1_busy_c6",  32'(busy),    32'd1);
    chk("t1_valid_c6", 32'(m_valid), 32'd0);
    tick();
    chk("t1_done_c7", 32'(done),     32'd0);
    chk("t1_busy_c7", 32'(busy),     32'd0);
    chk("t1_addr_c7", 32'(rom_addr), 32'd7);

    // 2: same burst, ready pattern 1,0,0 repeating
    start = 1;
    tick(); start = 0;
    acc = 0; have_prev = 0; got_done = 0; prev_data = '0;
    for (int c = 0; c < 40 && !got_done; c++) begin
      ready = ((c % 3) == 0);
      if (done) begin
        got_done = 1;
      end else begin
        if (have_prev) chk("t2_stable", 32'(m_data), 32'(prev_data));
        chk("t2_addr", 32'(rom_addr), 32'(3 + acc + int'(m_valid)));
        if (m_valid && ready) begin
          chk("t2_data", 32'(m_data), 32'(4 + acc));
          chk("t2_last", 32'(m_last), 32'(acc == 3));
          $display("t2 accepted word %0d data=%0d", acc, m_data);
          acc++;
          have_prev = 0;
        end else if (m_valid) begin
          have_prev = 1;
          prev_data = m_data;
        end
      end
      tick();
    end
    chk("t2_done_seen", 32'(got_done), 32'd1);
    chk("t2_count",     32'(acc),      32'd4);
    chk("t2_idle",      32'(busy),     32'd0);

    // 3: wrap, base=14 len=5 on DEPTH=16
    ready = 1; base = 4'd14; len = 5'd5; start = 1;
    tick(); start = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_valid", 32'(m_valid),  32'd1);
      chk("t3_data",  32'(m_data),   32'(((14 + i) % 16) + 1));
      chk("t3_addr",  32'(rom_addr), 32'((15 + i) % 16));
      chk("t3_last",  32'(m_last),   32'(i == 4));
      $display("t3 word %0d data=%0d addr=%0d", i, m_data, rom_addr);
    end
    tick();
    chk("t3_done", 32'(done), 32'd1);
    tick();

    // 3b: DEPTH=10, base=8 len=4 -> 9,10,1,2
    ready10 = 1; base10 = 4'd8; len10 = 5'd4; start10 = 1;
    tick(); start10 = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3b_valid", 32'(m_valid10), 32'd1);
      chk("t3b_data",  32'(m_data10),  32'(((8 + i) % 10) + 1));
      chk("t3b_last",  32'(m_last10),  32'(i == 3));
      $display("t3b word %0d data=%0d", i, m_data10);
    end
    tick();
    chk("t3b_done", 32'(done10), 32'd1);
    tick();
    // Out-of-range base on DEPTH=10 loads as 0
    base10 = 4'd12; len10 = 5'd1; start10 = 1;
    tick(); start10 = 0;
    tick();
    chk("t3b_oor_data", 32'(m_data10), 32'd1);
    chk("t3b_oor_last", 32'(m_last10), 32'd1);
    repeat (2) tick();

    // 4: len=0
    len = 5'd0; base = 4'd5; start = 1;
    tick(); start = 0;
    chk("t4_done_c1",  32'(done),    32'd1);
    chk("t4_busy_c1",  32'(busy),    32'd1);
    chk("t4_valid_c1", 32'(m_valid), 32'd0);
    tick();
    chk("t4_busy_c2",  32'(busy),    32'd0);
    chk("t4_done_c2",  32'(done),    32'd0);
    chk("t4_valid_c2", 32'(m_valid), 32'd0);

    // 5: abort while word 2 of 4 stalled
    base = 4'd0; len = 5'd4; ready = 0; start = 1;
    tick(); start = 0;
    tick();
    chk("t5_w1", 32'(m_data), 32'd1);
    ready = 1;
    tick(); ready = 0;
    tick();
    chk("t5_w2_stall", 32'(m_data),  32'd2);
    chk("t5_w2_valid", 32'(m_valid), 32'd1);
    abort = 1;
    tick(); abort = 0;
    chk("t5_ab_valid", 32'(m_valid), 32'd0);
    chk("t5_ab_last",  32'(m_last),  32'd0);
    chk("t5_ab_busy",  32'(busy),    32'd0);
    chk("t5_ab_done",  32'(done),    32'd0);
    tick();
    chk("t5_ab_done2", 32'(done), 32'd0);
    // abort + start together: abort wins
    abort = 1; start = 1;
    tick(); abort = 0; start = 0;
    chk("t5_abst_busy", 32'(busy), 32'd0);
    // fresh burst from its own base
    ready = 1; base = 4'd9; len = 5'd2; start = 1;
    tick(); start = 0;
    tick();
    chk("t5_new_d0", 32'(m_data), 32'd10);
    tick();
    chk("t5_new_d1",   32'(m_data), 32'd11);
    chk("t5_new_last", 32'(m_last), 32'd1);
    tick();
    chk("t5_new_done", 32'(done), 32'd1);
    tick();

    // 6: async reset mid-burst
    base = 4'd0; len = 5'd16; start = 1;
    tick(); start = 0;
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(m_valid), 32'd0);
    chk("t6_rst_last",  32'(m_last),  32'd0);
    chk("t6_rst_done",  32'(done),    32'd0);
    chk("t6_rst_busy",  32'(busy),    32'd0);
    rst_n = 1'b1;
    tick();
    chk("t6_post_done", 32'(done), 32'd0);
    chk("t6_post_busy", 32'(busy), 32'd0);

    // 6b: full-ROM burst, start during busy ignored
    base = 4'd0; len = 5'd16; start = 1;
    tick(); start = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 2) begin start = 1; base = 4'd7; len = 5'd3; end
      if (i == 3) start = 0;
      tick();
      chk("t6_valid", 32'(m_valid), 32'd1);
      chk("t6_data",  32'(m_data),  32'(i + 1));
      chk("t6_last",  32'(m_last),  32'(i == 15));
      $display("t6 word %0d data=%0d last=%0d", i, m_data, m_last);
    end
    tick();
    chk("t6_done", 32'(done), 32'd1);
    tick();
    chk("t6_idle",  32'(busy),    32'd0);
    chk("t6_noval", 32'(m_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
